fifo_wptr_full: RTL



---
 rtl/fifo_wptr_full_if.sv | 33 +++
 rtl/fifo_wptr_full.sv | 90 +++++++++
 2 files changed

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO pointer block; master is the pointer logic, slave the producer/RAM side.
// The overflow signal exists only when FIFO_OVERFLOW_DET_EN is defined.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   rptr_sync;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wcount;
`ifdef FIFO_OVERFLOW_DET_EN
  logic                  overflow;
`endif

  modport master (
    input  winc, rptr_sync,
    output wen, waddr, wptr, wfull, almost_full, wcount
`ifdef FIFO_OVERFLOW_DET_EN
    , output overflow
`endif
  );

  modport slave (
    output winc, rptr_sync,
    input  wen, waddr, wptr, wfull, almost_full, wcount
`ifdef FIFO_OVERFLOW_DET_EN
    , input overflow
`endif
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write pointer / full generator: wen+waddr same cycle, flags and Gray pointer one edge later, writes while full dropped.
// Optional sticky overflow flag under FIFO_OVERFLOW_DET_EN.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input logic            clk,
  input logic            reset,
  fifo_wptr_full_if.master bus
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AF_THRESH = (AW+1)'(ALMOST_FULL_THRESH);

  generate
    if (AW < 2) begin : g_bad_aw
      $error("fifo_wptr_full: ADDR_WIDTH must be at least 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > (1 << AW)) begin : g_bad_thresh
      $error("fifo_wptr_full: ALMOST_FULL_THRESH out of range");
    end
  endgenerate

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] wbin;
  logic [AW:0] wgray;
  logic        full_q;
  logic        afull_q;
  logic [AW:0] count_q;

  logic        accept;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] rbin;
  logic [AW:0] count_next;
  logic [AW:0] rptr_full_pat;

  assign accept     = bus.winc & ~full_q;
  assign wbin_next  = wbin + {{AW{1'b0}}, accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign rbin       = gray2bin(bus.rptr_sync);
  assign count_next = wbin_next - rbin;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign rptr_full_pat = {~bus.rptr_sync[AW:AW-1], bus.rptr_sync[AW-2:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      count_q <= '0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= (wgray_next == rptr_full_pat);
      afull_q <= (count_next >= AF_THRESH);
      count_q <= count_next;
    end
  end

`ifdef FIFO_OVERFLOW_DET_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.winc && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.wen         = accept;
  assign bus.waddr       = wbin[AW-1:0];
  assign bus.wptr        = wgray;
  assign bus.wfull       = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wcount      = count_q;
endmodule
